float_div_post: RTL and testbench
=================================

# float_div_post

Post-processing stage of the non-blocking floating-point divider. It sits directly downstream of the pipelined long-division mantissa divider. It delays the operand metadata (sign, exponent difference, operand class) so it stays aligned with the divider's fixed STEPS-cycle latency. It then normalises and rounds the raw quotient and packs an IEEE-754-style result with status flags, in a 2-stage pipeline.

## Interface
- EXP_W, 8, exponent width; bias = 2^(EXP_W-1)-1.
- MAN_W, 23, stored fraction width.
- STEPS, MAN_W+3, divider quotient width and latency in cycles; other values are unsupported.
- clk  in  1  clock, rising edge.
- nrst  in  1  asynchronous active-low reset.
- meta_valid  in  1  metadata strobe; asserted in the same cycle as the divider's input valid.
- meta_sign  in  1  sign_a XOR sign_b.
- meta_exp  in  EXP_W+2  signed two's complement value exp_a - exp_b + bias.
- meta_class  in  2  00 normal, 01 zero result, 10 infinity result, 11 NaN result.
- q_valid  in  1  divider output valid.
- quotient  in  STEPS  divider quotient; bit STEPS-1 is the integer bit, value in (0.5, 2).
- out_valid  out  1  result valid.
- out_data  out  1+EXP_W+MAN_W  packed {sign, exponent, fraction}.
- out_ovf  out  1  result saturated to infinity by exponent overflow.
- out_unf  out  1  result flushed to zero by exponent underflow.
- align_err  out  1  sticky: q_valid disagreed with the delayed meta_valid.

## Operation
- Metadata delay line: STEPS stages; the valid bit shifts every cycle and is reset to 0. Payload registers load only when the preceding stage's valid is 1 and have no reset. Delayed valid dv = meta_valid from STEPS cycles earlier.
- Cycle with dv != q_valid sets align_err. align_err clears only on reset. Stage 1 captures when q_valid=1, regardless of dv.
- Stage 1 (normalise), registered when q_valid=1:
  - If quotient[STEPS-1]=1: frac = quotient[STEPS-2:2], guard = quotient[1], e = meta_exp.
  - Else: frac = quotient[STEPS-3:1], guard = quotient[0], e = meta_exp-1.
- Stage 2 (round/pack), registered when stage-1 valid=1:
  - Rounding is round-to-nearest, ties away, on guard only; no sticky or remainder is used.
  - If frac is all ones and guard=1: frac=0, e=e+1.
  - Exponent checks use EXP_W+2-bit signed arithmetic after rounding.
  - e >= 2^EXP_W-1: output infinity, out_ovf=1.
  - e <= 0: output signed zero, out_unf=1. No subnormals are produced.
- Class override (from delayed metadata) takes precedence over the rounding result; out_ovf and out_unf are 0 in these cases:
  - zero: {sign, 0, 0}.
  - inf: {sign, all-ones exponent, 0}.
  - NaN: {0, all-ones exponent, 1 followed by zeros} (0x7FC00000 at default widths).
- Throughput is one result per cycle with no backpressure. Back-to-back valids are fully supported.

## Timing
- Latency: out_valid is asserted exactly 2 cycles after q_valid, i.e. STEPS+2 cycles after meta_valid.
- Reset values: out_valid=0, out_data=0, out_ovf=0, out_unf=0, align_err=0. All valid bits in the delay line and in stages 1–2 are 0.
- Reset mid-operation: every in-flight item is discarded, and no out_valid is asserted for inputs accepted before reset. The first valid after nrst rises is processed normally.
- Outputs hold their last value while out_valid=0.
- meta_valid and q_valid arriving in the same cycle refer to different items and are independent.

## Test plan
- 6.0/2.0: meta_exp=128, class 00, quotient=0x3000000 (26 bits) -> out_data=0x40400000 after 2 cycles, flags 0.
- 1.0/1.5: meta_exp=127, quotient=0x1555555 -> normalised with round-up, out_data=0x3F2AAAAB.
- Rounding carry: meta_exp=127, quotient=0x3FFFFFF -> out_data=0x40000000.
- Range limits:
  - meta_exp=255, quotient=0x3000000 -> 0x7F800000 with out_ovf=1.
  - meta_exp=0, sign=1, quotient=0x2000000 -> 0x80000000 with out_unf=1.
- Classes and streaming:
  - Class 11 -> 0x7FC00000; class 10 with sign=1 -> 0xFF800000.
  - 26 back-to-back items -> 26 consecutive results in order, aligned with their metadata.
- Faults and reset:
  - q_valid pulsed with no meta_valid STEPS cycles earlier -> align_err=1, held until reset.
  - nrst asserted with 5 items in flight -> no out_valid afterwards and all outputs 0.

Source files
------------

// File: rtl/float_div_post.sv
// Post-processing stage of the floating-point divider: aligns operand metadata
// with the mantissa divider latency, then normalises, rounds and packs the result.
module float_div_post #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int STEPS = MAN_W + 3
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   meta_valid,
  input  logic                   meta_sign,
  input  logic [EXP_W+1:0]       meta_exp,
  input  logic [1:0]             meta_class,
  input  logic                   q_valid,
  input  logic [STEPS-1:0]       quotient,
  output logic                   out_valid,
  output logic [EXP_W+MAN_W:0]   out_data,
  output logic                   out_ovf,
  output logic                   out_unf,
  output logic                   align_err
);

  localparam int EW = EXP_W + 2;
  localparam int DW = 1 + EXP_W + MAN_W;
  localparam int PW = 1 + 2 + EW;

  localparam logic [1:0] CLS_ZERO = 2'b01;
  localparam logic [1:0] CLS_INF  = 2'b10;
  localparam logic [1:0] CLS_NAN  = 2'b11;

  // metadata delay line: valid bits reset, payload only follows its valid
  logic [STEPS-1:0] dly_vld_q, dly_vld_d;
  logic [PW-1:0]    dly_pay_q [STEPS];
  logic [PW-1:0]    dly_pay_d [STEPS];

  logic             dv;
  logic             d_sign;
  logic [1:0]       d_cls;
  logic [EW-1:0]    d_exp;

  logic             s1_vld_q, s1_vld_d;
  logic [MAN_W-1:0] s1_frac_q, s1_frac_d;
  logic             s1_guard_q, s1_guard_d;
  logic [EW-1:0]    s1_exp_q, s1_exp_d;
  logic             s1_sign_q, s1_sign_d;
  logic [1:0]       s1_cls_q, s1_cls_d;

  logic             out_valid_q, out_valid_d;
  logic [DW-1:0]    out_data_q, out_data_d;
  logic             out_ovf_q, out_ovf_d;
  logic             out_unf_q, out_unf_d;
  logic             align_err_q, align_err_d;

  logic             carry;
  logic [MAN_W-1:0] frac_r;
  logic [EW-1:0]    exp_r;
  logic             ovf, unf;

  always_comb begin
    dly_vld_d    = {dly_vld_q[STEPS-2:0], meta_valid};
    dly_pay_d[0] = meta_valid ? {meta_sign, meta_class, meta_exp} : dly_pay_q[0];
    for (int i = 1; i < STEPS; i++) begin
      dly_pay_d[i] = dly_vld_q[i-1] ? dly_pay_q[i-1] : dly_pay_q[i];
    end
    dv                     = dly_vld_q[STEPS-1];
    {d_sign, d_cls, d_exp} = dly_pay_q[STEPS-1];
  end

  // stage 1: normalise so the integer bit is implicit
  always_comb begin
    s1_vld_d   = q_valid;
    s1_frac_d  = s1_frac_q;
    s1_guard_d = s1_guard_q;
    s1_exp_d   = s1_exp_q;
    s1_sign_d  = s1_sign_q;
    s1_cls_d   = s1_cls_q;
    if (q_valid) begin
      s1_sign_d = d_sign;
      s1_cls_d  = d_cls;
      if (quotient[STEPS-1]) begin
        s1_frac_d  = quotient[STEPS-2:2];
        s1_guard_d = quotient[1];
        s1_exp_d   = d_exp;
      end else begin
        s1_frac_d  = quotient[STEPS-3:1];
        s1_guard_d = quotient[0];
        s1_exp_d   = d_exp - {{(EW-1){1'b0}}, 1'b1};
      end
    end
    align_err_d = align_err_q | (dv != q_valid);
  end

  // stage 2: round on guard only (ties away), range check, class override
  always_comb begin
    {carry, frac_r} = {1'b0, s1_frac_q} + {{MAN_W{1'b0}}, s1_guard_q};
    exp_r           = s1_exp_q + {{(EW-1){1'b0}}, carry};
    ovf             = !exp_r[EW-1] && (exp_r[EW-2:0] >= {1'b0, {EXP_W{1'b1}}});
    unf             = exp_r[EW-1] || (exp_r == '0);

    out_valid_d = s1_vld_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;
    out_unf_d   = out_unf_q;
    if (s1_vld_q) begin
      out_ovf_d = 1'b0;
      out_unf_d = 1'b0;
      case (s1_cls_q)
        CLS_ZERO: out_data_d = {s1_sign_q, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
        CLS_INF:  out_data_d = {s1_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        CLS_NAN:  out_data_d = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
        default: begin
          if (ovf) begin
            out_data_d = {s1_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            out_ovf_d  = 1'b1;
          end else if (unf) begin
            out_data_d = {s1_sign_q, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
            out_unf_d  = 1'b1;
          end else begin
            out_data_d = {s1_sign_q, exp_r[EXP_W-1:0], frac_r};
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      dly_vld_q   <= '0;
      s1_vld_q    <= 1'b0;
      s1_frac_q   <= '0;
      s1_guard_q  <= 1'b0;
      s1_exp_q    <= '0;
      s1_sign_q   <= 1'b0;
      s1_cls_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
      out_unf_q   <= 1'b0;
      align_err_q <= 1'b0;
    end else begin
      dly_vld_q   <= dly_vld_d;
      s1_vld_q    <= s1_vld_d;
      s1_frac_q   <= s1_frac_d;
      s1_guard_q  <= s1_guard_d;
      s1_exp_q    <= s1_exp_d;
      s1_sign_q   <= s1_sign_d;
      s1_cls_q    <= s1_cls_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
      out_unf_q   <= out_unf_d;
      align_err_q <= align_err_d;
    end
  end

  always_ff @(posedge clk) begin
    dly_pay_q <= dly_pay_d;
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;
  assign out_unf   = out_unf_q;
  assign align_err = align_err_q;

endmodule

// File: tb/tb_float_div_post.sv
// Scoreboard bench for float_div_post: directed vectors, monitor checks
// result, flags and 2-cycle latency from q_valid.
module tb_float_div_post;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int STEPS = MAN_W + 3;
  localparam int NV    = 16;

  logic                 clk;
  logic                 nrst;
  logic                 meta_valid;
  logic                 meta_sign;
  logic [EXP_W+1:0]     meta_exp;
  logic [1:0]           meta_class;
  logic                 q_valid;
  logic [STEPS-1:0]     quotient;
  logic                 out_valid;
  logic [EXP_W+MAN_W:0] out_data;
  logic                 out_ovf;
  logic                 out_unf;
  logic                 align_err;

  float_div_post #(.EXP_W(EXP_W), .MAN_W(MAN_W), .STEPS(STEPS)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .meta_valid (meta_valid),
    .meta_sign  (meta_sign),
    .meta_exp   (meta_exp),
    .meta_class (meta_class),
    .q_valid    (q_valid),
    .quotient   (quotient),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ovf    (out_ovf),
    .out_unf    (out_unf),
    .align_err  (align_err)
  );

  typedef struct {
    logic        sign;
    logic [9:0]  exp;
    logic [1:0]  cls;
    logic [25:0] q;
    logic [31:0] data;
    logic        ovf;
    logic        unf;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        ovf;
    logic        unf;
    logic        chk;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic vec_t get_vec(input int i);
    vec_t v;
    case (i)
      0:  v = '{1'b0, 10'd128, 2'd0, 26'h3000000, 32'h40400000, 1'b0, 1'b0};
      1:  v = '{1'b0, 10'd127, 2'd0, 26'h1555555, 32'h3F2AAAAB, 1'b0, 1'b0};
      2:  v = '{1'b0, 10'd127, 2'd0, 26'h3FFFFFF, 32'h40000000, 1'b0, 1'b0};
      3:  v = '{1'b0, 10'd255, 2'd0, 26'h3000000, 32'h7F800000, 1'b1, 1'b0};
      4:  v = '{1'b1, 10'd0,   2'd0, 26'h2000000, 32'h80000000, 1'b0, 1'b1};
      5:  v = '{1'b0, 10'd127, 2'd3, 26'h2000000, 32'h7FC00000, 1'b0, 1'b0};
      6:  v = '{1'b1, 10'd127, 2'd2, 26'h2000000, 32'hFF800000, 1'b0, 1'b0};
      7:  v = '{1'b1, 10'd127, 2'd1, 26'h3000000, 32'h80000000, 1'b0, 1'b0};
      8:  v = '{1'b1, 10'd130, 2'd0, 26'h2000000, 32'hC1000000, 1'b0, 1'b0};
      9:  v = '{1'b0, 10'd254, 2'd0, 26'h2000000, 32'h7F000000, 1'b0, 1'b0};
      10: v = '{1'b0, 10'd254, 2'd0, 26'h3FFFFFF, 32'h7F800000, 1'b1, 1'b0};
      11: v = '{1'b0, 10'd2,   2'd0, 26'h1000000, 32'h00800000, 1'b0, 1'b0};
      12: v = '{1'b0, 10'h3FB, 2'd0, 26'h2000000, 32'h00000000, 1'b0, 1'b1};
      13: v = '{1'b1, 10'd255, 2'd3, 26'h3FFFFFF, 32'h7FC00000, 1'b0, 1'b0};
      14: v = '{1'b0, 10'd1,   2'd0, 26'h1000000, 32'h00000000, 1'b0, 1'b1};
      default: v = '{1'b0, 10'd1, 2'd0, 26'h1FFFFFF, 32'h00800000, 1'b0, 1'b0};
    endcase
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // meta for item i in iteration i, its quotient STEPS iterations later
  task automatic send_items(input int n, input int base);
    vec_t v;
    exp_t e;
    for (int c = 0; c < n + STEPS; c++) begin
      meta_valid = 1'b0;
      q_valid    = 1'b0;
      if (c < n) begin
        v          = get_vec((base + c) % NV);
        meta_valid = 1'b1;
        meta_sign  = v.sign;
        meta_exp   = v.exp;
        meta_class = v.cls;
      end
      if (c >= STEPS && c - STEPS < n) begin
        v        = get_vec((base + c - STEPS) % NV);
        q_valid  = 1'b1;
        quotient = v.q;
        e.data   = v.data;
        e.ovf    = v.ovf;
        e.unf    = v.unf;
        e.chk    = 1'b1;
        e.cyc    = cyc + 2;
        sb.push_back(e);
      end
      @(posedge clk); #1;
    end
    meta_valid = 1'b0;
    q_valid    = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // monitor: every out_valid must match the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (nrst === 1'b1 && out_valid === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_out_valid: got data %h with no pending item (cycle %0d)", out_data, cyc);
        end else begin
          e = sb.pop_front();
          chk("latency", cyc, e.cyc);
          if (e.chk) begin
            chk("out_data", out_data, e.data);
            chk("out_ovf", {31'b0, out_ovf}, {31'b0, e.ovf});
            chk("out_unf", {31'b0, out_unf}, {31'b0, e.unf});
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    exp_t e;
    nrst       = 1'b0;
    meta_valid = 1'b0;
    meta_sign  = 1'b0;
    meta_exp   = '0;
    meta_class = '0;
    q_valid    = 1'b0;
    quotient   = '0;
    idle(3);
    nrst = 1'b1;
    idle(1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_out_data",  out_data, 32'h0);
    chk("rst_out_ovf",   {31'b0, out_ovf}, 32'h0);
    chk("rst_out_unf",   {31'b0, out_unf}, 32'h0);
    chk("rst_align_err", {31'b0, align_err}, 32'h0);

    for (int k = 0; k < NV; k++) begin
      send_items(1, k);
    end
    idle(6);
    chk("hold_out_data", out_data, get_vec(NV - 1).data);
    chk("hold_out_valid", {31'b0, out_valid}, 32'h0);
    chk("align_err_single", {31'b0, align_err}, 32'h0);

    send_items(40, 3);
    idle(4);
    chk("stream_drained", sb.size(), 32'd0);
    chk("align_err_stream", {31'b0, align_err}, 32'h0);

    // orphan quotient: result content is stale metadata, so only latency is checked
    q_valid  = 1'b1;
    quotient = 26'h2000000;
    e.data = '0; e.ovf = 1'b0; e.unf = 1'b0; e.chk = 1'b0; e.cyc = cyc + 2;
    sb.push_back(e);
    idle(1);
    q_valid = 1'b0;
    idle(4);
    chk("align_err_set", {31'b0, align_err}, 32'h1);
    idle(10);
    chk("align_err_sticky", {31'b0, align_err}, 32'h1);
    chk("orphan_drained", sb.size(), 32'd0);

    // five items in flight, first already in stage 1, then reset
    for (int c = 0; c <= STEPS; c++) begin
      meta_valid = (c < 5);
      meta_sign  = 1'b0;
      meta_exp   = 10'd128;
      meta_class = 2'd0;
      q_valid    = (c == STEPS);
      quotient   = 26'h3000000;
      @(posedge clk); #1;
    end
    nrst       = 1'b0;
    meta_valid = 1'b0;
    q_valid    = 1'b0;
    idle(3);
    nrst = 1'b1;
    idle(1);
    chk("midrst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("midrst_out_data",  out_data, 32'h0);
    chk("midrst_out_ovf",   {31'b0, out_ovf}, 32'h0);
    chk("midrst_out_unf",   {31'b0, out_unf}, 32'h0);
    chk("midrst_align_err", {31'b0, align_err}, 32'h0);
    idle(40);
    chk("midrst_quiet_data", out_data, 32'h0);

    send_items(1, 1);
    idle(4);
    chk("post_reset_drained", sb.size(), 32'd0);
    chk("post_reset_align", {31'b0, align_err}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
